// File: rtl/ram_wait_ctrl_if.sv
// Requester/memory handshake bundle for ram_wait_ctrl.
// The master drives address, write data, direction and the enable level;
// the slave returns read data, completion and the range error flag.
interface ram_wait_ctrl_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
);
    logic [AW-1:0] MAR;
    logic          enable;
    logic [DW-1:0] bus;
    logic          rnw;
    logic [DW-1:0] MBR;
    logic          MFC;
    logic          err;

    modport master (
        output MAR, enable, bus, rnw,
        input  MBR, MFC, err
    );

    modport slave (
        input  MAR, enable, bus, rnw,
        output MBR, MFC, err
    );
endinterface

// File: rtl/ram_wait_ctrl.sv
// Clocked MAR/MBR/MFC memory block: one read or write per rising edge of
// enable, optional wait states before the access, four-phase completion on
// MFC and an error flag for addresses at or beyond DEPTH.
module ram_wait_ctrl #(
    parameter int unsigned   DW          = 8,
    parameter int unsigned   AW          = 8,
    parameter int unsigned   DEPTH       = 16,
    parameter int unsigned   WAIT_STATES = 0,
    parameter logic [DW-1:0] INIT0       = DW'(1)
) (
    input logic            clk,
    input logic            reset,
    ram_wait_ctrl_if.slave mem_if
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam int unsigned IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W   = (AW + 1)'(DEPTH);
    localparam logic [7:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : '0;

    state_t          r_state;
    state_t          w_nxt_state;
    logic            r_en_q;
    logic [7:0]      r_cnt;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic            r_rnw;
    logic [DW-1:0]   r_mbr;
    logic            r_mfc;
    logic            r_err;
    logic            w_req;
    logic            w_in_range;
    logic [IW-1:0]   w_idx;

    // Storage is never reset; only its power-up content is defined.
    logic [DW-1:0]   r_mem [DEPTH] = '{0: INIT0, default: '0};

    // Full-width compare: out-of-range addresses never alias into low bits.
    assign w_in_range = ({1'b0, r_addr} < DEPTH_W);
    assign w_idx      = r_addr[IW-1:0];

    assign mem_if.MBR = r_mbr;
    assign mem_if.MFC = r_mfc;
    assign mem_if.err = r_err;

    // Next-state: accept only a fresh rising edge of enable while idle.
    always_comb begin
        w_nxt_state = r_state;
        w_req       = mem_if.enable & ~r_en_q;
        case (r_state)
            S_IDLE:   if (w_req) w_nxt_state = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
            S_WAIT:   if (r_cnt == '0) w_nxt_state = S_ACCESS;
            S_ACCESS: w_nxt_state = S_DONE;
            S_DONE:   if (!mem_if.enable) w_nxt_state = S_IDLE;
            default:  w_nxt_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nxt_state;
        end
    end

    // Operand capture, wait countdown, read data, completion and error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_en_q  <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rnw   <= 1'b0;
            r_mbr   <= '0;
            r_mfc   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_en_q <= mem_if.enable;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= mem_if.MAR;
                        r_wdata <= mem_if.bus;
                        r_rnw   <= mem_if.rnw;
                        r_err   <= 1'b0;
                        r_cnt   <= WAIT_LOAD;
                    end
                end
                S_WAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 8'd1;
                end
                S_ACCESS: begin
                    r_mfc <= 1'b1;
                    if (w_in_range) begin
                        if (r_rnw) r_mbr <= r_mem[w_idx];
                    end else begin
                        r_err <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!mem_if.enable) r_mfc <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Write port: commits only in ACCESS, so a reset earlier drops the write.
    always_ff @(posedge clk) begin
        if (r_state == S_ACCESS && w_in_range && !r_rnw) begin
            r_mem[w_idx] <= r_wdata;
        end
    end
endmodule

// File: tb/tb_ram_wait_ctrl.sv
// Bench for ram_wait_ctrl: four instances (WAIT_STATES 0,2,3,4) share one
// requester; a cycle-level timestamp model predicts MFC/MBR/err for each.
`timescale 1ns/1ps
module tb_ram_wait_ctrl;
    localparam int N = 4;

    logic            clk = 1'b0;
    logic            r_reset = 1'b1;
    logic            r_en = 1'b0;
    logic            r_rnw = 1'b1;
    logic [7:0]      r_mar = '0;
    logic [7:0]      r_bus = '0;
    logic [N-1:0]    w_mfc;
    logic [N-1:0]    w_err;
    logic [7:0]      w_mbr [N];

    int total = 0;
    int bad   = 0;
    int exp_lat [N] = '{2, 4, 5, 6};

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int unsigned WS = (g == 0) ? 0 : g + 1;
        ram_wait_ctrl_if #(.DW(8), .AW(8)) u_if ();
        assign u_if.MAR    = r_mar;
        assign u_if.enable = r_en;
        assign u_if.bus    = r_bus;
        assign u_if.rnw    = r_rnw;
        assign w_mfc[g]    = u_if.MFC;
        assign w_err[g]    = u_if.err;
        assign w_mbr[g]    = u_if.MBR;
        ram_wait_ctrl #(
            .DW(8), .AW(8), .DEPTH(16), .WAIT_STATES(WS), .INIT0(8'h01)
        ) u_dut (
            .clk(clk),
            .reset(r_reset),
            .mem_if(u_if)
        );
    end

    function automatic int ws_of(input int i);
        return (i == 0) ? 0 : i + 1;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int         cyc = 0;
    bit         m_busy [N];
    int         m_due  [N];
    logic       m_mfc  [N];
    logic       m_err  [N];
    logic [7:0] m_mbr  [N];
    logic [7:0] m_addr [N];
    logic [7:0] m_data [N];
    logic       m_rnw  [N];
    logic [7:0] m_mem  [N][16];
    logic       m_prev_en = 1'b0;

    initial begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 16; j++) m_mem[i][j] = (j == 0) ? 8'h01 : 8'h00;
            m_busy[i] = 0; m_mfc[i] = 0; m_err[i] = 0; m_mbr[i] = '0; m_due[i] = 0;
        end
        forever begin
            @(posedge clk or posedge r_reset);
            if (r_reset) begin
                for (int i = 0; i < N; i++) begin
                    m_busy[i] = 0; m_mfc[i] = 0; m_err[i] = 0; m_mbr[i] = '0;
                end
                m_prev_en = 1'b0;
            end else begin
                cyc++;
                for (int i = 0; i < N; i++) begin
                    if (!m_busy[i] && !m_mfc[i]) begin
                        if (r_en && !m_prev_en) begin
                            m_addr[i] = r_mar; m_data[i] = r_bus; m_rnw[i] = r_rnw;
                            m_err[i]  = 1'b0;
                            m_busy[i] = 1;
                            m_due[i]  = cyc + 1 + ws_of(i);
                        end
                    end else if (m_busy[i]) begin
                        if (cyc == m_due[i]) begin
                            if (m_addr[i] >= 8'd16) m_err[i] = 1'b1;
                            else if (m_rnw[i]) m_mbr[i] = m_mem[i][m_addr[i][3:0]];
                            else m_mem[i][m_addr[i][3:0]] = m_data[i];
                            m_busy[i] = 0;
                            m_mfc[i]  = 1'b1;
                        end
                    end else if (!r_en) begin
                        m_mfc[i] = 1'b0;
                    end
                end
                m_prev_en = r_en;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                chk($sformatf("mfc[%0d]", i), 8'(w_mfc[i]), 8'(m_mfc[i]));
                chk($sformatf("err[%0d]", i), 8'(w_err[i]), 8'(m_err[i]));
                chk($sformatf("mbr[%0d]", i), w_mbr[i], m_mbr[i]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic start(input logic rnw, input logic [7:0] mar, input logic [7:0] data);
        @(posedge clk); #1;
        r_rnw = rnw; r_mar = mar; r_bus = data; r_en = 1'b1;
    endtask

    // Next posedge is the request edge; latency counts edges inclusive of it.
    task automatic wait_mfc(input bit chk_lat);
        int lat [N];
        int edges = 0;
        logic [N-1:0] seen = '0;
        for (int i = 0; i < N; i++) lat[i] = 0;
        while (seen != '1 && edges < 30) begin
            @(posedge clk); edges++;
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (!seen[i] && w_mfc[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = edges;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            chk($sformatf("mfc_seen[%0d]", i), 8'(seen[i]), 8'd1);
            if (chk_lat) chk($sformatf("latency[%0d]", i), 8'(lat[i]), 8'(exp_lat[i]));
        end
    endtask

    task automatic release_en();
        int edges = 0;
        @(posedge clk); #1 r_en = 1'b0;
        do begin
            @(posedge clk); edges++;
            @(negedge clk);
        end while (w_mfc != '0 && edges < 10);
        chk("mfc_drop_edges", 8'(edges), 8'd1);
    endtask

    task automatic chk_mbr_all(input string name, input logic [7:0] exp);
        for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", name, i), w_mbr[i], exp);
    endtask

    task automatic chk_err_all(input string name, input logic exp);
        for (int i = 0; i < N; i++) chk($sformatf("%s[%0d]", name, i), 8'(w_err[i]), 8'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int hi [N];

        // 1: enable held high across reset release is a request; read word 0.
        r_reset = 1'b1; r_en = 1'b1; r_rnw = 1'b1; r_mar = 8'h00; r_bus = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) chk($sformatf("rst_mfc[%0d]", i), 8'(w_mfc[i]), 8'd0);
        chk_mbr_all("rst_mbr", 8'h00);
        chk_err_all("rst_err", 1'b0);
        @(posedge clk); #1 r_reset = 1'b0;
        wait_mfc(1);
        chk_mbr_all("t1_mbr", 8'h01);
        chk_err_all("t1_err", 1'b0);
        release_en();

        // 2: write then read back; the write leaves MBR alone.
        start(1'b0, 8'd7, 8'hA5); wait_mfc(1);
        chk_mbr_all("t2_wr_mbr", 8'h01);
        release_en();
        start(1'b1, 8'd7, 8'h00); wait_mfc(1);
        chk_mbr_all("t2_rd_mbr", 8'hA5);
        release_en();

        // 3: out of range write (0x10), last legal word (0x0F), word 0 intact.
        start(1'b0, 8'h10, 8'hFF); wait_mfc(0);
        chk_err_all("t3_err_hi", 1'b1);
        chk_mbr_all("t3_mbr_hi", 8'hA5);
        release_en();
        start(1'b1, 8'h00, 8'h00); wait_mfc(0);
        chk_err_all("t3_err_lo", 1'b0);
        chk_mbr_all("t3_mbr_w0", 8'h01);
        release_en();
        start(1'b0, 8'h0F, 8'h5E); wait_mfc(0); release_en();
        start(1'b1, 8'h0F, 8'h00); wait_mfc(0);
        chk_mbr_all("t3_mbr_w15", 8'h5E);
        chk_err_all("t3_err_w15", 1'b0);
        release_en();

        // 4: enable dropped right after the request edge: one-cycle MFC pulse.
        start(1'b0, 8'd2, 8'h3C);
        @(posedge clk); #1 r_en = 1'b0;
        for (int i = 0; i < N; i++) hi[i] = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if (w_mfc[i]) hi[i]++;
        end
        for (int i = 0; i < N; i++) chk($sformatf("t4_pulse[%0d]", i), 8'(hi[i]), 8'd1);
        start(1'b1, 8'd2, 8'h00); wait_mfc(0);
        chk_mbr_all("t4_mbr", 8'h3C);
        release_en();

        // 5: held enable with changing operands must not start a second access.
        start(1'b0, 8'd5, 8'h5A); wait_mfc(0);
        repeat (10) begin
            @(posedge clk); #1 r_bus = 8'hC3; r_mar = 8'd6; r_rnw = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) chk($sformatf("t5_held[%0d]", i), 8'(w_mfc[i]), 8'd1);
        release_en();
        start(1'b1, 8'd5, 8'h00); wait_mfc(0);
        chk_mbr_all("t5_one_write", 8'h5A);
        release_en();
        start(1'b1, 8'd6, 8'h00); wait_mfc(0);
        chk_mbr_all("t5_no_stray", 8'h00);
        release_en();
        start(1'b0, 8'd5, 8'hC3); wait_mfc(0);
        // enable low for a single edge (DONE -> IDLE) then straight back high
        @(posedge clk); #1 r_en = 1'b0; r_rnw = 1'b1;
        @(posedge clk); #1 r_en = 1'b1;
        wait_mfc(1);
        chk_mbr_all("t5_toggle", 8'hC3);
        release_en();

        // 6: reset one edge after a write request.
        start(1'b0, 8'd3, 8'h77);
        @(posedge clk);
        @(posedge clk); #1 r_reset = 1'b1;
        #1;
        for (int i = 0; i < N; i++) chk($sformatf("t6_mfc[%0d]", i), 8'(w_mfc[i]), 8'd0);
        chk_mbr_all("t6_mbr", 8'h00);
        r_en = 1'b0;
        @(posedge clk); #1 r_reset = 1'b0;
        start(1'b1, 8'd3, 8'h00); wait_mfc(0);
        // only the zero-wait instance finished its access before reset
        chk("t6_rd[0]", w_mbr[0], 8'h77);
        for (int i = 1; i < N; i++) chk($sformatf("t6_rd[%0d]", i), w_mbr[i], 8'h00);
        release_en();

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
